// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   rxState_e    - receive FSM state encoding
//   PRESCALE_MIN - smallest supported clocks-per-bit value
//   PRESCALE_MAX - largest supported clocks-per-bit value
//   PAR_EVEN/ODD - encodings of the par_typ input
//   calcParity() - parity bit for a data word, shared with the TX parity calculator
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rxState_e;

  localparam int PRESCALE_MIN = 8;
  localparam int PRESCALE_MAX = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR
  // reduction unchanged. Odd parity is even parity inverted.
  function automatic logic calcParity(input logic [31:0] data, input logic parTyp);
    return (^data) ^ parTyp;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority voter for uart_rx.
//   clk          - oversampling clock
//   rest         - synchronous active-high reset
//   rxIn_i       - serial line
//   active_i     - a frame is in progress (counter runs)
//   start_i      - start bit detected this cycle; the counter restarts at 1
//   clear_i      - abort the current frame; the counter returns to 0
//   prescale_i   - latched clocks per bit
//   wrap_o       - last clock of the current bit period
//   sampleDone_o - majority of the three mid-bit samples is valid this cycle
//   bitValue_o   - 2-of-3 majority of the mid-bit samples
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  rxIn_i,
  input  logic                  active_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  wrap_o,
  output logic                  sampleDone_o,
  output logic                  bitValue_o
);

  logic [PRESCALE_W-1:0] edgeCnt_q, edgeCnt_d;
  logic [2:0]            samples_q, samples_d;
  logic [PRESCALE_W-1:0] half;

  assign half         = prescale_i >> 1;
  assign wrap_o       = active_i && (edgeCnt_q == prescale_i - PRESCALE_W'(1));
  assign sampleDone_o = active_i && (edgeCnt_q == half + PRESCALE_W'(2));
  assign bitValue_o   = (samples_q[0] & samples_q[1]) |
                        (samples_q[0] & samples_q[2]) |
                        (samples_q[1] & samples_q[2]);

  // Next-state logic for the edge counter and the three sample slots.
  // The start cycle itself counts as edge 0 of the start bit, so the
  // counter restarts at 1 rather than 0. Samples are taken one clock
  // either side of mid-bit so a single-cycle glitch is voted out.
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    samples_d = samples_q;

    if (start_i) begin
      edgeCnt_d = PRESCALE_W'(1);
    end else if (clear_i || !active_i || wrap_o) begin
      edgeCnt_d = '0;
    end else begin
      edgeCnt_d = edgeCnt_q + PRESCALE_W'(1);
    end

    if (active_i) begin
      if (edgeCnt_q == half - PRESCALE_W'(1)) samples_d[0] = rxIn_i;
      if (edgeCnt_q == half)                  samples_d[1] = rxIn_i;
      if (edgeCnt_q == half + PRESCALE_W'(1)) samples_d[2] = rxIn_i;
    end
  end

  // Register stage for the counter and samples.
  always_ff @(posedge clk) begin
    if (rest) begin
      edgeCnt_q <= '0;
      samples_q <= '0;
    end else begin
      edgeCnt_q <= edgeCnt_d;
      samples_q <= samples_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive deserializer with optional parity and stop-bit check.
//   clk        - receive oversampling clock
//   rest       - synchronous active-high reset
//   rx_in      - serial line, idle high, already synchronised to clk
//   par_en     - a parity bit follows the data bits
//   par_typ    - 0 even parity, 1 odd parity
//   prescale   - clocks per bit (even, 8..32), latched at the start bit
//   p_data     - last good received byte
//   data_valid - one-cycle pulse when p_data updates
//   par_err    - one-cycle pulse, parity mismatch
//   stp_err    - one-cycle pulse, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  rxState_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  parEn_q, parEn_d;
  logic                  parTyp_q, parTyp_d;
  logic                  parFail_q, parFail_d;
  logic                  stpFail_q, stpFail_d;
  logic [DATA_WIDTH-1:0] pData_q, pData_d;
  logic                  dataValid_q, dataValid_d;
  logic                  parErr_q, parErr_d;
  logic                  stpErr_q, stpErr_d;

  logic startDet, clearCnt, wrap, sampleDone, bitValue;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) sampler (
    .clk          (clk),
    .rest         (rest),
    .rxIn_i       (rx_in),
    .active_i     (state_q != ST_IDLE),
    .start_i      (startDet),
    .clear_i      (clearCnt),
    .prescale_i   (prescale_q),
    .wrap_o       (wrap),
    .sampleDone_o (sampleDone),
    .bitValue_o   (bitValue)
  );

  // Frame FSM, data shifting and checks. Failures are only remembered
  // during the frame and reported together on the stop-bit wrap, so the
  // output pulses land in the cycle the FSM is already back in IDLE and a
  // back-to-back start bit is not missed.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    prescale_d  = prescale_q;
    parEn_d     = parEn_q;
    parTyp_d    = parTyp_q;
    parFail_d   = parFail_q;
    stpFail_d   = stpFail_q;
    pData_d     = pData_q;
    dataValid_d = 1'b0;
    parErr_d    = 1'b0;
    stpErr_d    = 1'b0;
    startDet    = 1'b0;
    clearCnt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          state_d    = ST_START;
          startDet   = 1'b1;
          prescale_d = prescale;
          parEn_d    = par_en;
          parTyp_d   = par_typ;
          bitCnt_d   = '0;
          parFail_d  = 1'b0;
          stpFail_d  = 1'b0;
        end
      end

      ST_START: begin
        // A start bit that is high again by mid-bit was line noise.
        if (sampleDone && bitValue) begin
          state_d  = ST_IDLE;
          clearCnt = 1'b1;
        end else if (wrap) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // Shifting in at the MSB leaves the first (LSB) bit at bit 0.
        if (sampleDone) shift_d = {bitValue, shift_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          if (bitCnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bitCnt_d = '0;
            state_d  = parEn_q ? ST_PARITY : ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (sampleDone && (bitValue != calcParity(32'(shift_q), parTyp_q))) parFail_d = 1'b1;
        if (wrap) state_d = ST_STOP;
      end

      ST_STOP: begin
        if (sampleDone && !bitValue) stpFail_d = 1'b1;
        if (wrap) begin
          state_d  = ST_IDLE;
          parErr_d = parFail_q;
          stpErr_d = stpFail_q;
          if (!parFail_q && !stpFail_q) begin
            dataValid_d = 1'b1;
            pData_d     = shift_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without flags.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      prescale_q  <= '0;
      parEn_q     <= 1'b0;
      parTyp_q    <= 1'b0;
      parFail_q   <= 1'b0;
      stpFail_q   <= 1'b0;
      pData_q     <= '0;
      dataValid_q <= 1'b0;
      parErr_q    <= 1'b0;
      stpErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      prescale_q  <= prescale_d;
      parEn_q     <= parEn_d;
      parTyp_q    <= parTyp_d;
      parFail_q   <= parFail_d;
      stpFail_q   <= stpFail_d;
      pData_q     <= pData_d;
      dataValid_q <= dataValid_d;
      parErr_q    <= parErr_d;
      stpErr_q    <= stpErr_d;
    end
  end

  assign p_data     = pData_q;
  assign data_valid = dataValid_q;
  assign par_err    = parErr_q;
  assign stp_err    = stpErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven testbench for uart_rx.
// Each table entry describes one serial frame with hand-computed results.
// Two hand-written sequences cover a false start bit and a mid-frame reset.
module tb_uart_rx;

  typedef struct {
    int         p;
    logic       parEn;
    logic       parTyp;
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    logic       glitch;
    logic       chained;
    logic       expValid;
    logic       expPar;
    logic       expStp;
    logic [7:0] expData;
  } frameVec_t;

  logic       clk = 1'b0;
  logic       rest;
  logic       rxIn;
  logic       parEn;
  logic       parTyp;
  logic [5:0] prescale;
  logic [7:0] pData;
  logic       dataValid;
  logic       parErr;
  logic       stpErr;

  int checkCount = 0;
  int passCount  = 0;
  int curFrame   = -1;

  frameVec_t vecs[11];

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk        (clk),
    .rest       (rest),
    .rx_in      (rxIn),
    .par_en     (parEn),
    .par_typ    (parTyp),
    .prescale   (prescale),
    .p_data     (pData),
    .data_valid (dataValid),
    .par_err    (parErr),
    .stp_err    (stpErr)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports a failure with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s (frame %0d): got 0x%0h, expected 0x%0h", name, curFrame, actual, expected);
    end
  endtask

  // Line level during cycle k of a frame: start, 8 data bits LSB first,
  // optional parity, stop. The glitch option inverts mid-bit of data bits.
  function automatic logic frameBit(input frameVec_t v, input int k);
    int   idx;
    int   pos;
    logic b;
    idx = k / v.p;
    pos = k % v.p;
    if (idx == 0)                    b = 1'b0;
    else if (idx <= 8)               b = v.data[idx-1];
    else if (v.parEn && idx == 9)    b = v.parBit;
    else                             b = v.stopBit;
    if (v.glitch && idx >= 1 && idx <= 8 && pos == v.p / 2) b = ~b;
    return b;
  endfunction

  // Drives one frame cycle by cycle at the falling edge, checks no flag
  // fires before the frame end, then checks the frame-end outputs.
  // Config inputs are scrambled after cycle 0 to show they are latched.
  task automatic applyStimulus(input frameVec_t v, input logic chained);
    int f;
    int quietHits;
    f = (v.parEn ? 11 : 10) * v.p;
    quietHits = 0;
    for (int k = 0; k <= f; k++) begin
      if (!(k == 0 && chained)) @(negedge clk);
      if ((k > 0 || !chained) && k < f && (dataValid || parErr || stpErr)) quietHits++;
      if (k == 0) begin
        prescale = 6'(v.p);
        parEn    = v.parEn;
        parTyp   = v.parTyp;
      end
      if (k == 1) begin
        prescale = 6'd12;
        parEn    = ~v.parEn;
        parTyp   = ~v.parTyp;
      end
      if (k < f) begin
        rxIn = frameBit(v, k);
      end else begin
        checkOutput("data_valid", 32'(dataValid), 32'(v.expValid));
        checkOutput("par_err",    32'(parErr),    32'(v.expPar));
        checkOutput("stp_err",    32'(stpErr),    32'(v.expStp));
        checkOutput("p_data",     32'(pData),     32'(v.expData));
        rxIn = 1'b1;
      end
    end
    checkOutput("quiet_before_end", 32'(quietHits), 32'd0);
  endtask

  // Start bit low for only 4 cycles at P=16: mid-bit majority is high,
  // so the receiver must drop the frame silently.
  task automatic falseStartSequence();
    int hits;
    hits = 0;
    prescale = 6'd16;
    parEn    = 1'b0;
    parTyp   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dataValid || parErr || stpErr) hits++;
      rxIn = (k < 4) ? 1'b0 : 1'b1;
    end
    checkOutput("false_start_quiet", 32'(hits), 32'd0);
  endtask

  // Frame 0x77 at P=8 aborted by reset during data bit 4 (cycle 43).
  task automatic resetSequence();
    frameVec_t v;
    int hits;
    v = '{p: 8, parEn: 1'b0, parTyp: 1'b0, data: 8'h77, parBit: 1'b0, stopBit: 1'b1,
          glitch: 1'b0, chained: 1'b0, expValid: 1'b0, expPar: 1'b0, expStp: 1'b0, expData: 8'h00};
    hits = 0;
    prescale = 6'd8;
    parEn    = 1'b0;
    parTyp   = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (dataValid || parErr || stpErr) hits++;
      rxIn = frameBit(v, k);
    end
    @(negedge clk);
    rest = 1'b1;
    rxIn = 1'b1;
    @(negedge clk);
    checkOutput("reset_p_data",     32'(pData),     32'd0);
    checkOutput("reset_data_valid", 32'(dataValid), 32'd0);
    rest = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (dataValid || parErr || stpErr) hits++;
    end
    checkOutput("reset_quiet", 32'(hits), 32'd0);
  endtask

  initial begin
    //           p   pe    pt    data   pb    stop  glt   chn   valid par   stp   expData
    vecs[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[2]  = '{8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81};
    vecs[5]  = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[6]  = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[7]  = '{32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[9]  = '{8,  1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
    vecs[10] = '{8,  1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12};

    rest     = 1'b1;
    rxIn     = 1'b1;
    parEn    = 1'b0;
    parTyp   = 1'b0;
    prescale = 6'd8;
    repeat (3) @(negedge clk);
    checkOutput("reset_p_data",     32'(pData),     32'd0);
    checkOutput("reset_data_valid", 32'(dataValid), 32'd0);
    checkOutput("reset_par_err",    32'(parErr),    32'd0);
    checkOutput("reset_stp_err",    32'(stpErr),    32'd0);
    rest = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      curFrame = i;
      if (i == 5)  falseStartSequence();
      if (i == 10) resetSequence();
      applyStimulus(vecs[i], vecs[i].chained);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
